tx_prbs_gen: RTL
================

TX_PRBS_GEN -- requirements
Module: tx_prbs_gen

Interface
REQ-001 Parameter SEED_DFLT, default 31'h7FFF_FFFF, LFSR contents loaded at reset.
REQ-002 Parameter ERRCNT_W, default 8, width of the injected-error counter.
REQ-003 Port clk, input, 1: TX bit clock, the same clock that drives the downstream 2-tap FIR driver.
REQ-004 Port rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port en, input, 1: advance pattern one bit per clk while high.
REQ-006 Port mode, input, 2: 0=PRBS7, 1=PRBS15, 2=PRBS31, 3=clock pattern (1010...).
REQ-007 Port seed_ld, input, 1: load seed into LFSR on this edge.
REQ-008 Port seed, input, 31: seed value, LSB-aligned; only the active width is used.
REQ-009 Port err_inj, input, 1: request a single-bit inversion of the output stream.
REQ-010 Port out, output, 1: serial TX data, drives the FIR driver data input.
REQ-011 Port valid, output, 1: high while out carries live pattern data.
REQ-012 Port err_cnt, output, ERRCNT_W: number of errors injected, saturating.

Function
REQ-013 The block SHALL hold a 31-bit Fibonacci LFSR s[30:0]; active width N = 7/15/31 for mode 0/1/2.
REQ-014 The feedback SHALL be fb = s[6]^s[5] (PRBS7), s[14]^s[13] (PRBS15), s[30]^s[27] (PRBS31).
REQ-015 On each enabled edge the block SHALL update s <= {s[29:0],fb}, then mask bits at and above N to 0.
REQ-016 On each enabled edge the block SHALL register out <= fb ^ inj, giving one cycle of latency from en to the first new bit.
REQ-017 In mode 3 the block SHALL toggle out every enabled edge, with the first enabled bit after reset or seed_ld equal to 1; the LFSR holds.
REQ-018 The FSM SHALL have the states IDLE and RUN: IDLE->RUN on an edge with en=1 and seed_ld=0; RUN->IDLE on an edge with en=0; valid=1 only in RUN.
REQ-019 In IDLE, or when en=0, out and s SHALL hold their values.
REQ-020 When seed_ld=1, s SHALL load seed masked to N, out holds, and the FSM goes to IDLE; seed_ld has priority over en on the same edge.
REQ-021 A zero masked seed (from a load or a mode change) SHALL be replaced by all-ones of width N, so that no lock-up state is possible.
REQ-022 A mode change SHALL take effect on the next enabled edge; s is re-masked to the new N, with zero replaced per REQ-021.
REQ-023 err_inj SHALL set a pending flag; the next enabled edge inverts out, clears the flag, and increments err_cnt.
REQ-024 Multiple err_inj pulses before an enabled edge SHALL produce a single inversion; err_inj coincident with an enabled edge applies on that edge.
REQ-025 err_cnt SHALL saturate at 2^ERRCNT_W-1 and never wrap.

Reset
REQ-026 rstn low SHALL asynchronously force s=SEED_DFLT masked to PRBS7 width (7'h7F by default), out=0, valid=0, state=IDLE, err_cnt=0, and the pending flag=0.
REQ-027 Reset mid-stream SHALL discard the pending injection; the first enabled edge after release produces the mode's first bit from the reset seed.

Structure
REQ-028 Mode encodings, tap positions, active widths, and the IDLE/RUN state enum SHALL live in a shared package, tx_prbs_pkg.
REQ-029 The LFSR next-state/feedback logic SHALL be one sub-module, prbs_lfsr_step; the FSM, error injection, and counter stay in tx_prbs_gen.

Verification
REQ-030 Reset, mode=0, en=1 continuously -> out for enabled edges 1..8 = 0,0,0,0,0,0,1,0; the sequence repeats with period 127.
REQ-031 Modes 1 and 2 run for 2^N-1 bits -> the sequence repeats exactly with period 32767 and 2^31-1 respectively (PRBS31 check by a checker LFSR lock, 10k bits error-free).
REQ-032 seed_ld=1 with seed=0 and en=1 on the same edge -> out holds, valid=0, s=7'h7F; the next enabled edge produces out=0.
REQ-033 Three err_inj pulses while en=0, then en=1 -> exactly one inverted bit versus a reference model, err_cnt=1.
REQ-034 Mode 3 -> out toggles 1,0,1,0...; rstn pulsed mid-stream -> out=0, valid=0, err_cnt=0 immediately, without waiting for clk.
REQ-035 With ERRCNT_W=2, inject 5 errors -> err_cnt saturates at 3.

Source files
------------

// File: rtl/tx_prbs_pkg.sv
// -----------------------------------------------------------------------------
// tx_prbs_pkg
// Shared definitions for the TX PRBS generator: mode encodings, LFSR tap
// positions, active-width masks, the IDLE/RUN state enum, and the helper that
// masks an LFSR value to the active width (replacing an all-zero result with
// all-ones so the generator can never lock up).
// -----------------------------------------------------------------------------
package tx_prbs_pkg;

    localparam int LFSR_W = 31;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS31 = 2'd2,
        MODE_CLK    = 2'd3
    } prbs_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } prbs_state_e;

    // Feedback taps: fb = s[TAP_A] ^ s[TAP_B]
    localparam int PRBS7_TAP_A  = 6;
    localparam int PRBS7_TAP_B  = 5;
    localparam int PRBS15_TAP_A = 14;
    localparam int PRBS15_TAP_B = 13;
    localparam int PRBS31_TAP_A = 30;
    localparam int PRBS31_TAP_B = 27;

    // Active-width masks (N = 7 / 15 / 31)
    localparam logic [LFSR_W-1:0] PRBS7_MASK  = 31'h0000_007F;
    localparam logic [LFSR_W-1:0] PRBS15_MASK = 31'h0000_7FFF;
    localparam logic [LFSR_W-1:0] PRBS31_MASK = 31'h7FFF_FFFF;

    // Clock-pattern mode has no active width; it keeps the full register.
    function automatic logic [LFSR_W-1:0] width_mask(input logic [1:0] mode);
        logic [LFSR_W-1:0] m;
        case (mode)
            MODE_PRBS7:  m = PRBS7_MASK;
            MODE_PRBS15: m = PRBS15_MASK;
            default:     m = PRBS31_MASK;
        endcase
        return m;
    endfunction

    function automatic logic [LFSR_W-1:0] mask_state(input logic [LFSR_W-1:0] v,
                                                     input logic [1:0]        mode);
        logic [LFSR_W-1:0] m;
        logic [LFSR_W-1:0] r;
        m = width_mask(mode);
        r = v & m;
        if (r == '0) begin
            r = m;
        end
        return r;
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// -----------------------------------------------------------------------------
// prbs_lfsr_step
// Combinational single-step of the Fibonacci PRBS LFSR. The current state is
// first re-masked to the active width of the requested mode (so a mode change
// takes effect on the step itself), then the feedback bit is formed and
// shifted in at bit 0.
// Ports:
//   s      in  31  current LFSR contents
//   mode   in  2   0=PRBS7 1=PRBS15 2=PRBS31 3=clock pattern (fb unused)
//   fb     out 1   feedback bit = next serial PRBS bit
//   s_next out 31  next LFSR contents, masked to the active width
// -----------------------------------------------------------------------------
module prbs_lfsr_step
    import tx_prbs_pkg::*;
(
    input  logic [LFSR_W-1:0] s,
    input  logic [1:0]        mode,
    output logic              fb,
    output logic [LFSR_W-1:0] s_next
);

    logic [LFSR_W-1:0] s_eff;

    always_comb begin
        s_eff = mask_state(s, mode);
        case (mode)
            MODE_PRBS7:  fb = s_eff[PRBS7_TAP_A]  ^ s_eff[PRBS7_TAP_B];
            MODE_PRBS15: fb = s_eff[PRBS15_TAP_A] ^ s_eff[PRBS15_TAP_B];
            MODE_PRBS31: fb = s_eff[PRBS31_TAP_A] ^ s_eff[PRBS31_TAP_B];
            default:     fb = 1'b0;
        endcase
        s_next = {s_eff[LFSR_W-2:0], fb} & width_mask(mode);
    end

endmodule

// File: rtl/tx_prbs_gen.sv
// -----------------------------------------------------------------------------
// tx_prbs_gen
// Serial TX pattern generator (PRBS7/15/31 or 1010 clock pattern) with seed
// load, single-bit error injection and a saturating injected-error counter.
// Ports:
//   clk      in  1         TX bit clock (shared with the 2-tap FIR driver)
//   rstn     in  1         asynchronous active-low reset
//   en       in  1         advance the pattern one bit per clk
//   mode     in  2         0=PRBS7 1=PRBS15 2=PRBS31 3=clock pattern
//   seed_ld  in  1         load seed into the LFSR (wins over en)
//   seed     in  31        seed value, LSB-aligned
//   err_inj  in  1         request a single inversion of the output stream
//   out      out 1         serial TX data
//   valid    out 1         out carries live pattern data
//   err_cnt  out ERRCNT_W  number of injected errors, saturating
// -----------------------------------------------------------------------------
module tx_prbs_gen
    import tx_prbs_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DFLT = 31'h7FFF_FFFF,
    parameter int                ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                seed_ld,
    input  logic [LFSR_W-1:0]   seed,
    input  logic                err_inj,
    output logic                out,
    output logic                valid,
    output logic [ERRCNT_W-1:0] err_cnt
);

    // Reset always starts in PRBS7 width.
    localparam logic [LFSR_W-1:0] SEED_RST = mask_state(SEED_DFLT, MODE_PRBS7);

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    prbs_state_e       state_q;
    prbs_state_e       state_d;
    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_next;
    logic              fb;
    logic              out_q;
    logic              clk_ph_q;   // last clock-pattern bit, before injection
    logic              pend_q;
    logic [ERRCNT_W-1:0] err_cnt_q;
    logic              inj;
    logic              is_clk;

    prbs_lfsr_step u_step (
        .s      (s_q),
        .mode   (mode),
        .fb     (fb),
        .s_next (s_next)
    );

    // A request arriving on the enabled edge itself is applied on that edge.
    assign inj    = pend_q | err_inj;
    assign is_clk = (mode == MODE_CLK);

    // ---- state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en && !seed_ld) state_d = ST_RUN;
            ST_RUN:  if (!en || seed_ld) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- output logic
    always_comb begin
        valid = (state_q == ST_RUN);
    end

    // ---- pattern datapath, injection and counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q       <= SEED_RST;
            out_q     <= 1'b0;
            clk_ph_q  <= 1'b0;
            pend_q    <= 1'b0;
            err_cnt_q <= '0;
        end else if (seed_ld) begin
            s_q      <= mask_state(seed, mode);
            clk_ph_q <= 1'b0;
            pend_q   <= pend_q | err_inj;
        end else if (en) begin
            if (is_clk) begin
                clk_ph_q <= ~clk_ph_q;
                out_q    <= ~clk_ph_q ^ inj;
            end else begin
                s_q   <= s_next;
                out_q <= fb ^ inj;
            end
            pend_q <= 1'b0;
            if (inj) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end else begin
            pend_q <= pend_q | err_inj;
        end
    end

    assign out     = out_q;
    assign err_cnt = err_cnt_q;

endmodule
